// File: rtl/branch_resolve_ctrl_pkg.sv
// otter_branch_pkg: shared funct3 codes, FSM state type and pc+4 helper for branch resolution
package otter_branch_pkg;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} br_state_t;
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/br_cond_unit.sv
// br_cond_unit: combinational comparator (a, b -> eq, signed lt, unsigned ltu)
module br_cond_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);
  assign eq  = a == b;
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: one-at-a-time branch/jump resolver with redirect, timed flush and saturating perf counters
module branch_resolve_ctrl
  import otter_branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_is_jump,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_target,
  input  logic             req_pred_taken,
  input  logic             kill,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             mispredict,
  output logic             illegal,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  br_state_t   state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  funct3;
  logic        is_jump, pred;
  logic [31:0] rs1, rs2, pc, target;
  logic        eq, lt, ltu, ev, ill_c, cond, taken_c, mis_c;
  br_cond_unit u_cond (.a(rs1), .b(rs2), .eq(eq), .lt(lt), .ltu(ltu));
  // funct3[0] inverts the base compare (NE/GE/GEU); 01x is unused for branches
  assign ill_c   = !is_jump && (funct3[2:1] == 2'b01);
  assign cond    = (funct3[2] ? (funct3[1] ? ltu : lt) : eq) ^ funct3[0];
  assign taken_c = is_jump || (!ill_c && cond);
  assign mis_c   = taken_c ^ pred;
  assign ev      = (state == EVAL) && !kill;
  assign req_ready      = rst_n && (state == IDLE);
  assign resolve_valid  = ev;
  assign resolve_taken  = ev && taken_c;
  assign illegal        = ev && ill_c;
  assign mispredict     = ev && mis_c;
  assign redirect_valid = ev && mis_c;
  assign redirect_pc    = ev ? (taken_c ? target : pc_plus4(pc)) : 32'd0;
  assign flush          = (ev && mis_c) || (state == FLUSH);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE:  state_nx = (req_valid && !kill) ? EVAL : IDLE;
      EVAL: begin
        state_nx = (!kill && mis_c && FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        cnt_nx   = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        state_nx = (kill || cnt == 4'd1) ? IDLE : FLUSH;
        cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      funct3           <= '0;
      is_jump          <= 1'b0;
      pred             <= 1'b0;
      rs1              <= '0;
      rs2              <= '0;
      pc               <= '0;
      target           <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req_valid && !kill) begin
        funct3  <= req_funct3;
        is_jump <= req_is_jump;
        pred    <= req_pred_taken;
        rs1     <= req_rs1;
        rs2     <= req_rs2;
        pc      <= req_pc;
        target  <= req_target;
      end
      if (ev) begin
        branch_count <= (&branch_count) ? branch_count : branch_count + 1'b1;
        if (mis_c)
          mispredict_count <= (&mispredict_count) ? mispredict_count : mispredict_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks of branch_resolve_ctrl against a rule-level model
module tb_branch_resolve_ctrl;
  localparam int FC = 2;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_is_jump = 0, req_pred_taken = 0, kill = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, req_pc = 0, req_target = 0;
  logic        req_ready, resolve_valid, resolve_taken, mispredict, illegal, redirect_valid, flush;
  logic [31:0] redirect_pc, branch_count, mispredict_count;
  logic        s_ready, s_rv, s_rt, s_mis, s_ill, s_redv, s_flush;
  logic [31:0] s_rpc;
  logic [3:0]  s_bc, s_mc;
  int errors = 0, checks = 0;
  longint n_br = 0, n_mis = 0;
  always #5 clk = ~clk;
  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_is_jump(req_is_jump), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_target(req_target), .req_pred_taken(req_pred_taken), .kill(kill),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .mispredict(mispredict),
    .illegal(illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count));
  branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_ready),
    .req_funct3(req_funct3), .req_is_jump(req_is_jump), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_target(req_target), .req_pred_taken(req_pred_taken), .kill(kill),
    .resolve_valid(s_rv), .resolve_taken(s_rt), .mispredict(s_mis),
    .illegal(s_ill), .redirect_valid(s_redv), .redirect_pc(s_rpc), .flush(s_flush),
    .branch_count(s_bc), .mispredict_count(s_mc));
  function automatic void ref_model(input logic [2:0] f3, input logic j, input logic [31:0] a, b,
                                    output logic t, output logic il);
    il = 0;
    case (f3)
      3'd0: t = a == b;
      3'd1: t = a != b;
      3'd4: t = $signed(a) < $signed(b);
      3'd5: t = $signed(a) >= $signed(b);
      3'd6: t = a < b;
      3'd7: t = a >= b;
      default: begin t = 0; il = 1; end
    endcase
    if (j) begin t = 1; il = 0; end
  endfunction
  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFFFFFF) ? 32'hFFFFFFFF : v[31:0];
  endfunction
  function automatic logic [3:0] sat4(input longint v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction
  // km: 0 plain, 1 kill during EVAL, 2 kill during first FLUSH cycle
  task automatic do_req(input string nm, input logic [2:0] f3, input logic j, input logic [31:0] a, b, pc, tgt,
                        input logic pr, input int km);
    logic et, eil, emis;
    logic [31:0] epc;
    ref_model(f3, j, a, b, et, eil);
    emis = et ^ pr;
    epc = et ? tgt : pc + 32'd4;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before got=%b exp=1", nm, req_ready); end
    req_valid = 1; req_funct3 = f3; req_is_jump = j; req_rs1 = a; req_rs2 = b;
    req_pc = pc; req_target = tgt; req_pred_taken = pr;
    @(negedge clk);
    req_valid = 0; req_rs1 = $urandom; req_rs2 = $urandom; req_pc = $urandom; req_funct3 = 3'($urandom);
    kill = (km == 1);
    #1;
    checks++;
    if (km == 1) begin
      if ({resolve_valid, mispredict, redirect_valid, flush, req_ready} !== 5'b0) begin
        errors++; $display("FAIL %s eval_killed got rv,mis,redv,flush,rdy=%b exp=00000", nm,
          {resolve_valid, mispredict, redirect_valid, flush, req_ready});
      end
    end else begin
      if ({resolve_valid, resolve_taken, illegal, mispredict, redirect_valid, flush, req_ready}
          !== {1'b1, et, eil, emis, emis, emis, 1'b0}) begin
        errors++; $display("FAIL %s eval got rv,t,ill,mis,redv,flush,rdy=%b exp=%b", nm,
          {resolve_valid, resolve_taken, illegal, mispredict, redirect_valid, flush, req_ready},
          {1'b1, et, eil, emis, emis, emis, 1'b0});
      end
      if (emis) begin
        checks++;
        if (redirect_pc !== epc) begin errors++; $display("FAIL %s redirect_pc got=%h exp=%h", nm, redirect_pc, epc); end
      end
      n_br++;
      if (emis) n_mis++;
    end
    if (km != 1 && emis)
      for (int i = 1; i < FC; i++) begin
        @(negedge clk);
        kill = (km == 2 && i == 1);
        #1;
        checks++;
        if ({flush, redirect_valid, resolve_valid, req_ready} !== 4'b1000) begin
          errors++; $display("FAIL %s flush_hold%0d got flush,redv,rv,rdy=%b exp=1000", nm, i,
            {flush, redirect_valid, resolve_valid, req_ready});
        end
        if (km == 2) break;
      end
    @(negedge clk);
    kill = 0;
    #1;
    checks++;
    if ({flush, req_ready, resolve_valid} !== 3'b010) begin
      errors++; $display("FAIL %s after got flush,rdy,rv=%b exp=010", nm, {flush, req_ready, resolve_valid});
    end
    checks++;
    if (branch_count !== sat32(n_br) || mispredict_count !== sat32(n_mis) || s_bc !== sat4(n_br) || s_mc !== sat4(n_mis)) begin
      errors++; $display("FAIL %s counters got bc=%0d mc=%0d sbc=%0d smc=%0d exp bc=%0d mc=%0d sbc=%0d smc=%0d", nm,
        branch_count, mispredict_count, s_bc, s_mc, sat32(n_br), sat32(n_mis), sat4(n_br), sat4(n_mis));
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resolve_valid, resolve_taken, mispredict, illegal, redirect_valid, flush} !== 7'b0
        || redirect_pc !== 0 || branch_count !== 0 || mispredict_count !== 0) begin
      errors++; $display("FAIL reset_outputs got rdy..flush=%b rpc=%h bc=%0d mc=%0d exp all 0",
        {req_ready, resolve_valid, resolve_taken, mispredict, illegal, redirect_valid, flush},
        redirect_pc, branch_count, mispredict_count);
    end
    rst_n = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_br = 0; n_mis = 0;
  endtask
  task automatic test_directed();
    do_req("beq_taken", 3'b000, 0, 32'h5, 32'h5, 32'h100, 32'h80, 1, 0);
    do_req("blt_signed", 3'b100, 0, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h240, 0, 0);
    do_req("bltu_unsigned", 3'b110, 0, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h240, 0, 0);
    do_req("bne_wrap", 3'b001, 0, 32'h77, 32'h77, 32'hFFFFFFFC, 32'h1000, 1, 0);
    do_req("illegal_010", 3'b010, 0, 32'h3, 32'h3, 32'h400, 32'h500, 1, 0);
    do_req("illegal_011", 3'b011, 0, 32'h3, 32'h4, 32'h404, 32'h500, 0, 0);
    do_req("jump_010", 3'b010, 1, 32'h3, 32'h3, 32'h400, 32'h500, 1, 0);
    do_req("jump_mispred", 3'b101, 1, 32'h0, 32'h9, 32'h600, 32'h700, 0, 0);
    do_req("bgeu", 3'b111, 0, 32'h80000000, 32'h7FFFFFFF, 32'h800, 32'h900, 1, 0);
  endtask
  task automatic test_kill();
    do_req("kill_eval_bge", 3'b101, 0, 32'h10, 32'h2, 32'hA00, 32'hB00, 0, 1);
    do_req("kill_flush_blt", 3'b100, 0, 32'h80000000, 32'h0, 32'hC00, 32'hD00, 0, 2);
    @(negedge clk);
    req_valid = 1; kill = 1; req_funct3 = 3'b000; req_rs1 = 1; req_rs2 = 2; req_pred_taken = 1;
    @(negedge clk);
    req_valid = 0; kill = 0;
    #1;
    checks++;
    if ({resolve_valid, req_ready, flush} !== 3'b010) begin
      errors++; $display("FAIL kill_idle got rv,rdy,flush=%b exp=010", {resolve_valid, req_ready, flush});
    end
  endtask
  task automatic test_back_to_back_random();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, b, pc;
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = -a;
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : {$urandom, 2'b00};
      do_req("random", 3'($urandom), $urandom_range(0, 4) == 0, a, b, pc, {$urandom, 2'b00},
             1'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 17; i++)
      do_req("sat", 3'b000, 0, 32'h1, 32'h1, 32'h40, 32'h80, 0, 0);
    checks++;
    if (s_bc !== 4'hF || s_mc !== 4'hF) begin
      errors++; $display("FAIL saturate got sbc=%h smc=%h exp=f f", s_bc, s_mc);
    end
  endtask
  task automatic test_reset_mid_flush();
    @(negedge clk);
    req_valid = 1; req_funct3 = 3'b100; req_is_jump = 0; req_rs1 = 32'hFFFFFFFF; req_rs2 = 1; req_pred_taken = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #1;
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL rst_mid pre_flush got=%b exp=1", flush); end
    rst_n = 0;
    #1;
    checks++;
    if ({flush, req_ready, resolve_valid} !== 3'b000 || branch_count !== 0 || mispredict_count !== 0 || s_bc !== 0) begin
      errors++; $display("FAIL rst_mid got flush,rdy,rv=%b bc=%0d mc=%0d sbc=%0d exp 000 0 0 0",
        {flush, req_ready, resolve_valid}, branch_count, mispredict_count, s_bc);
    end
    n_br = 0; n_mis = 0;
    @(negedge clk);
    rst_n = 1;
    do_req("post_reset", 3'b001, 0, 32'h1, 32'h2, 32'h20, 32'h30, 0, 0);
  endtask
  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_back_to_back_random();
    test_saturate();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
